arb_requester: RTL and testbench

Requester-side endpoint for the team's req/gnt arbitration interface. It buffers transactions from a local valid/ready source in a small FIFO and raises a level `req` toward a fixed- or base-priority arbiter while data is pending. On each cycle the arbiter grants it, the block pops one entry onto the shared bus. It also tracks how long it has waited and flags starvation so a higher level can rotate `base`.

---
 rtl/arb_pkg.sv | 9 +
 rtl/sync_fifo.sv | 58 +++++
 rtl/arb_requester.sv | 102 ++++++++++
 tb/tb_arb_requester.sv | 225 ++++++++++++++++++++++
 4 files changed

// File: rtl/arb_pkg.sv
// Shared types for the req/gnt arbitration endpoints.
package arb_pkg;

   typedef enum logic [0:0] {
      ERR_NONE     = 1'b0,
      ERR_SPURIOUS = 1'b1
   } arb_err_e;

endpackage : arb_pkg

// File: rtl/sync_fifo.sv
// Flop-based synchronous FIFO with a combinational head and an occupancy count.
// Callers guard push/pop; pointers wrap modulo DEPTH (power of 2).
module sync_fifo #(
   parameter int unsigned DATA_W = 32,
   parameter int unsigned DEPTH  = 4
) (
   input  logic                    clk,
   input  logic                    rst,
   input  logic                    push,
   input  logic                    pop,
   input  logic [DATA_W-1:0]       wdata,
   output logic [DATA_W-1:0]       rdata,
   output logic [$clog2(DEPTH):0]  count
);

   localparam int unsigned PTR_W = $clog2(DEPTH);
   localparam int unsigned CNT_W = PTR_W + 1;

   logic [DATA_W-1:0] mem_q [DEPTH];
   logic [DATA_W-1:0] mem_d [DEPTH];
   logic [PTR_W-1:0]  wr_ptr_q, wr_ptr_d;
   logic [PTR_W-1:0]  rd_ptr_q, rd_ptr_d;
   logic [CNT_W-1:0]  count_q, count_d;

   always_comb begin
      mem_d    = mem_q;
      wr_ptr_d = wr_ptr_q;
      rd_ptr_d = rd_ptr_q;
      count_d  = count_q + CNT_W'(push) - CNT_W'(pop);
      if (push) begin
         mem_d[wr_ptr_q] = wdata;
         wr_ptr_d        = wr_ptr_q + PTR_W'(1);
      end
      if (pop) begin
         rd_ptr_d = rd_ptr_q + PTR_W'(1);
      end
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         wr_ptr_q <= '0;
         rd_ptr_q <= '0;
         count_q  <= '0;
         for (int unsigned i = 0; i < DEPTH; i++) begin
            mem_q[i] <= '0;
         end
      end else begin
         wr_ptr_q <= wr_ptr_d;
         rd_ptr_q <= rd_ptr_d;
         count_q  <= count_d;
         mem_q    <= mem_d;
      end
   end

   assign rdata = mem_q[rd_ptr_q];
   assign count = count_q;

endmodule : sync_fifo

// File: rtl/arb_requester.sv
// Requester endpoint: buffers source beats, requests the arbiter while data is
// pending, pops one beat per grant, and flags starvation and spurious grants.
module arb_requester
   import arb_pkg::*;
#(
   parameter int unsigned DATA_W       = 32,
   parameter int unsigned DEPTH        = 4,
   parameter int unsigned STARVE_LIMIT = 15
) (
   input  logic                    clk,
   input  logic                    rst,
   input  logic                    in_valid,
   output logic                    in_ready,
   input  logic [DATA_W-1:0]       in_data,
   output logic                    req,
   input  logic                    gnt,
   output logic                    out_valid,
   output logic [DATA_W-1:0]       out_data,
   output logic [$clog2(DEPTH):0]  level,
   output logic                    urgent,
   output logic                    err_spurious
);

   localparam int unsigned LVL_W  = $clog2(DEPTH) + 1;
   localparam int unsigned WAIT_W = $clog2(STARVE_LIMIT + 1);

   logic              push_c;
   logic              pop_c;
   logic [DATA_W-1:0] head_c;

   logic              out_valid_q, out_valid_d;
   logic [DATA_W-1:0] out_data_q, out_data_d;
   logic [WAIT_W-1:0] wait_cnt_q, wait_cnt_d;
   arb_err_e          err_q, err_d;

   // req comes from registered occupancy only, so no gnt->req loop exists.
   assign in_ready = (level != LVL_W'(DEPTH));
   assign req      = (level != '0);
   assign push_c   = in_valid && in_ready;
   assign pop_c    = req && gnt;

   sync_fifo #(
      .DATA_W (DATA_W),
      .DEPTH  (DEPTH)
   ) u_fifo (
      .clk   (clk),
      .rst   (rst),
      .push  (push_c),
      .pop   (pop_c),
      .wdata (in_data),
      .rdata (head_c),
      .count (level)
   );

   // Output register, starvation counter and sticky error state.
   always_comb begin
      out_valid_d = pop_c;
      out_data_d  = out_data_q;
      wait_cnt_d  = wait_cnt_q;
      err_d       = err_q;

      if (pop_c) begin
         out_data_d = head_c;
      end

      if (pop_c || (level == '0)) begin
         wait_cnt_d = '0;
      end else if (req && !gnt && (wait_cnt_q != WAIT_W'(STARVE_LIMIT))) begin
         wait_cnt_d = wait_cnt_q + WAIT_W'(1);
      end

      case (err_q)
         ERR_NONE: begin
            if (gnt && !req) begin
               err_d = ERR_SPURIOUS;
            end
         end
         ERR_SPURIOUS: err_d = ERR_SPURIOUS;
         default:      err_d = ERR_NONE;
      endcase
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         out_valid_q <= 1'b0;
         out_data_q  <= '0;
         wait_cnt_q  <= '0;
         err_q       <= ERR_NONE;
      end else begin
         out_valid_q <= out_valid_d;
         out_data_q  <= out_data_d;
         wait_cnt_q  <= wait_cnt_d;
         err_q       <= err_d;
      end
   end

   assign out_valid    = out_valid_q;
   assign out_data     = out_data_q;
   assign urgent       = (wait_cnt_q == WAIT_W'(STARVE_LIMIT));
   assign err_spurious = (err_q == ERR_SPURIOUS);

endmodule : arb_requester

// File: tb/tb_arb_requester.sv
// Self-checking bench for arb_requester: vector table, corner-case sequences,
// and a queue-based scoreboard monitor checking every cycle.
module tb_arb_requester;

   localparam int unsigned DATA_W = 32;
   localparam int unsigned DEPTH  = 4;
   localparam int unsigned SLIM   = 15;

   logic              clk;
   logic              rst;
   logic              in_valid;
   logic              in_ready;
   logic [DATA_W-1:0] in_data;
   logic              req;
   logic              gnt;
   logic              out_valid;
   logic [DATA_W-1:0] out_data;
   logic [2:0]        level;
   logic              urgent;
   logic              err_spurious;

   logic              gnt_tie;
   logic              gnt_drv;

   int n_chk  = 0;
   int n_pass = 0;
   bit started = 1'b0;

   assign gnt = gnt_tie ? req : gnt_drv;

   arb_requester #(
      .DATA_W       (DATA_W),
      .DEPTH        (DEPTH),
      .STARVE_LIMIT (SLIM)
   ) dut (
      .clk          (clk),
      .rst          (rst),
      .in_valid     (in_valid),
      .in_ready     (in_ready),
      .in_data      (in_data),
      .req          (req),
      .gnt          (gnt),
      .out_valid    (out_valid),
      .out_data     (out_data),
      .level        (level),
      .urgent       (urgent),
      .err_spurious (err_spurious)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
      n_chk++;
      if (act === exp) n_pass++;
      else $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", nm, act, exp, $time);
   endtask

   // Scoreboard model, sampled on the falling edge.
   logic [DATA_W-1:0] sb_q[$];
   logic              m_exp_valid = 1'b0;
   logic [DATA_W-1:0] m_exp_data  = '0;
   int                m_wcnt      = 0;
   logic              m_err       = 1'b0;
   logic              m_req;
   logic              m_full;

   always @(negedge clk) begin
      m_req  = (sb_q.size() != 0);
      m_full = (sb_q.size() == DEPTH);
      if (started) begin
         chk("mon_out_valid", 32'(out_valid), 32'(m_exp_valid));
         chk("mon_out_data", out_data, m_exp_data);
         chk("mon_level", 32'(level), 32'(sb_q.size()));
         chk("mon_req", 32'(req), 32'(m_req));
         chk("mon_in_ready", 32'(in_ready), 32'(!m_full));
         chk("mon_urgent", 32'(urgent), 32'(m_wcnt == SLIM));
         chk("mon_err", 32'(err_spurious), 32'(m_err));
      end
      if (rst) begin
         sb_q.delete();
         m_exp_valid = 1'b0;
         m_exp_data  = '0;
         m_wcnt      = 0;
         m_err       = 1'b0;
      end else begin
         if (gnt && !m_req) m_err = 1'b1;
         if (m_req && gnt) begin
            m_exp_valid = 1'b1;
            m_exp_data  = sb_q.pop_front();
            m_wcnt      = 0;
         end else begin
            m_exp_valid = 1'b0;
            if (!m_req) m_wcnt = 0;
            else if (m_wcnt != SLIM) m_wcnt++;
         end
         if (in_valid && !m_full) sb_q.push_back(in_data);
      end
   end

   typedef struct {
      logic        rst;
      logic        iv;
      logic [31:0] d;
      logic        tie;
      logic        g;
      logic        ov;
      logic [31:0] od;
      logic [2:0]  lvl;
      logic        rq;
      logic        rdy;
      logic        urg;
   } vec_t;

   vec_t tbl[15];

   task automatic cyc(input logic r, input logic iv, input logic [31:0] d, input logic g);
      rst      = r;
      in_valid = iv;
      in_data  = d;
      gnt_tie  = 1'b0;
      gnt_drv  = g;
      @(posedge clk);
      #1;
   endtask

   initial begin
      rst = 1'b1; in_valid = 1'b0; in_data = '0; gnt_tie = 1'b0; gnt_drv = 1'b0;

      //          rst   iv    data      tie   g   | ov    od        lvl   rq    rdy   urg
      tbl[0]  = '{1'b1, 1'b0, 32'h0,  1'b0, 1'b0, 1'b0, 32'h0,  3'd0, 1'b0, 1'b1, 1'b0};
      tbl[1]  = '{1'b0, 1'b1, 32'hA5, 1'b1, 1'b0, 1'b0, 32'h0,  3'd1, 1'b1, 1'b1, 1'b0};
      tbl[2]  = '{1'b0, 1'b0, 32'h0,  1'b1, 1'b0, 1'b1, 32'hA5, 3'd0, 1'b0, 1'b1, 1'b0};
      tbl[3]  = '{1'b0, 1'b0, 32'h0,  1'b1, 1'b0, 1'b0, 32'hA5, 3'd0, 1'b0, 1'b1, 1'b0};
      tbl[4]  = '{1'b0, 1'b1, 32'h11, 1'b0, 1'b0, 1'b0, 32'hA5, 3'd1, 1'b1, 1'b1, 1'b0};
      tbl[5]  = '{1'b0, 1'b1, 32'h22, 1'b0, 1'b0, 1'b0, 32'hA5, 3'd2, 1'b1, 1'b1, 1'b0};
      tbl[6]  = '{1'b0, 1'b1, 32'h33, 1'b0, 1'b0, 1'b0, 32'hA5, 3'd3, 1'b1, 1'b1, 1'b0};
      tbl[7]  = '{1'b0, 1'b1, 32'h44, 1'b0, 1'b0, 1'b0, 32'hA5, 3'd4, 1'b1, 1'b0, 1'b0};
      tbl[8]  = '{1'b0, 1'b1, 32'h55, 1'b0, 1'b0, 1'b0, 32'hA5, 3'd4, 1'b1, 1'b0, 1'b0};
      tbl[9]  = '{1'b0, 1'b1, 32'h55, 1'b0, 1'b1, 1'b1, 32'h11, 3'd3, 1'b1, 1'b1, 1'b0};
      tbl[10] = '{1'b0, 1'b1, 32'h55, 1'b0, 1'b1, 1'b1, 32'h22, 3'd3, 1'b1, 1'b1, 1'b0};
      tbl[11] = '{1'b0, 1'b0, 32'h0,  1'b0, 1'b1, 1'b1, 32'h33, 3'd2, 1'b1, 1'b1, 1'b0};
      tbl[12] = '{1'b0, 1'b0, 32'h0,  1'b0, 1'b1, 1'b1, 32'h44, 3'd1, 1'b1, 1'b1, 1'b0};
      tbl[13] = '{1'b0, 1'b0, 32'h0,  1'b0, 1'b1, 1'b1, 32'h55, 3'd0, 1'b0, 1'b1, 1'b0};
      tbl[14] = '{1'b0, 1'b0, 32'h0,  1'b0, 1'b0, 1'b0, 32'h55, 3'd0, 1'b0, 1'b1, 1'b0};

      for (int i = 0; i < 15; i++) begin
         rst      = tbl[i].rst;
         in_valid = tbl[i].iv;
         in_data  = tbl[i].d;
         gnt_tie  = tbl[i].tie;
         gnt_drv  = tbl[i].g;
         @(posedge clk);
         #1;
         started = 1'b1;
         chk($sformatf("vec%0d_out_valid", i), 32'(out_valid), 32'(tbl[i].ov));
         chk($sformatf("vec%0d_out_data", i), out_data, tbl[i].od);
         chk($sformatf("vec%0d_level", i), 32'(level), 32'(tbl[i].lvl));
         chk($sformatf("vec%0d_req", i), 32'(req), 32'(tbl[i].rq));
         chk($sformatf("vec%0d_in_ready", i), 32'(in_ready), 32'(tbl[i].rdy));
         chk($sformatf("vec%0d_urgent", i), 32'(urgent), 32'(tbl[i].urg));
      end

      // Starvation: one entry, never granted, then a single grant.
      cyc(1'b1, 1'b0, 32'h0, 1'b0);
      cyc(1'b0, 1'b1, 32'h77, 1'b0);
      for (int i = 1; i <= 16; i++) begin
         cyc(1'b0, 1'b0, 32'h0, 1'b0);
         chk($sformatf("starve%0d_urgent", i), 32'(urgent), 32'(i >= 15));
      end
      cyc(1'b0, 1'b0, 32'h0, 1'b1);
      chk("starve_pop_valid", 32'(out_valid), 32'd1);
      chk("starve_pop_data", out_data, 32'h77);
      chk("starve_clear_urgent", 32'(urgent), 32'd0);
      chk("starve_clear_wait", 32'(dut.wait_cnt_q), 32'd0);

      // Spurious grant: ignored, sticky until reset.
      cyc(1'b1, 1'b0, 32'h0, 1'b0);
      cyc(1'b0, 1'b0, 32'h0, 1'b1);
      chk("spur_no_valid", 32'(out_valid), 32'd0);
      chk("spur_err_set", 32'(err_spurious), 32'd1);
      for (int i = 0; i < 3; i++) begin
         cyc(1'b0, 1'b0, 32'h0, 1'b0);
         chk("spur_err_sticky", 32'(err_spurious), 32'd1);
      end
      cyc(1'b0, 1'b1, 32'h99, 1'b1);
      chk("spur_push_level", 32'(level), 32'd1);
      chk("spur_push_no_valid", 32'(out_valid), 32'd0);
      cyc(1'b1, 1'b0, 32'h0, 1'b0);
      chk("spur_err_reset", 32'(err_spurious), 32'd0);
      chk("spur_reset_level", 32'(level), 32'd0);

      // Simultaneous push/pop at level 2; ordering checked by the scoreboard.
      cyc(1'b0, 1'b1, 32'h1000, 1'b0);
      cyc(1'b0, 1'b1, 32'h2000, 1'b0);
      for (int i = 0; i < 20; i++) begin
         cyc(1'b0, 1'b1, $urandom(), 1'b1);
         chk("pp_level", 32'(level), 32'd2);
         chk("pp_out_valid", 32'(out_valid), 32'd1);
      end
      cyc(1'b0, 1'b0, 32'h0, 1'b1);
      cyc(1'b0, 1'b0, 32'h0, 1'b1);
      chk("pp_drained", 32'(level), 32'd0);

      // Reset while draining with level 3.
      cyc(1'b0, 1'b1, 32'hC1, 1'b0);
      cyc(1'b0, 1'b1, 32'hC2, 1'b0);
      cyc(1'b0, 1'b1, 32'hC3, 1'b0);
      cyc(1'b0, 1'b1, 32'hC4, 1'b1);
      chk("rd_level_pre", 32'(level), 32'd3);
      cyc(1'b1, 1'b1, 32'hAB, 1'b1);
      chk("rd_req", 32'(req), 32'd0);
      chk("rd_out_valid", 32'(out_valid), 32'd0);
      chk("rd_level", 32'(level), 32'd0);
      chk("rd_in_ready", 32'(in_ready), 32'd1);
      chk("rd_out_data", out_data, 32'h0);
      cyc(1'b0, 1'b0, 32'h0, 1'b0);
      chk("rd_after_valid", 32'(out_valid), 32'd0);
      cyc(1'b0, 1'b0, 32'h0, 1'b0);

      $display("%0d/%0d checks passed", n_pass, n_chk);
      $finish;
   end

endmodule : tb_arb_requester
